// File: rtl/tcm_dec_tmu_tree_n.sv
// Trellis metric unit for the 4D-8PSK TCM decoder: saturating group sums feeding a
// pipelined binary compare tree that selects the best candidate per beat.
module tcm_dec_tmu_tree_n #(
  parameter int pSYMB_M_W = 8,
  parameter int pSUM_N    = 4,
  parameter int pGROUP_N  = 4,
  parameter int pBM_W     = pSYMB_M_W + 2
) (
  input  logic                                      iclk,
  input  logic                                      ireset_n,
  input  logic                                      iclkena,
  input  logic                                      ival,
  input  logic [pGROUP_N*pSUM_N*pSYMB_M_W-1:0]      isymb_m,
  input  logic [$clog2(pGROUP_N):0]                 imode,
  input  logic                                      isop,
  input  logic                                      ieop,
  output logic                                      oval,
  output logic [pBM_W-1:0]                          obm,
  output logic [$clog2(pGROUP_N)-1:0]               osymb_m_idx,
  output logic                                      osop,
  output logic                                      oeop,
  output logic                                      osat
);

  localparam int LOG_G   = $clog2(pGROUP_N);
  localparam int L       = 2 + LOG_G;
  localparam int NODES   = 2 * pGROUP_N - 1;
  localparam int SUM_NAT = pSYMB_M_W + $clog2(pSUM_N);
  localparam int ACC_W   = ((SUM_NAT > pBM_W) ? SUM_NAT : pBM_W) + 1;

  typedef struct packed {
    logic [pBM_W-1:0] val;
    logic [LOG_G-1:0] idx;
    logic             sat;
    logic             vld;
  } node_t;

  logic [L-1:0]           vld_pipe;
  logic [L-1:0]           sop_pipe;
  logic [L-1:0]           eop_pipe;
  logic [ACC_W-1:0]       pre_c  [pGROUP_N];
  logic [ACC_W-1:0]       pre_r  [pGROUP_N];
  logic [pSYMB_M_W-1:0]   last_r [pGROUP_N];
  logic [LOG_G:0]         mode_r;
  node_t                  leaf_c [pGROUP_N];
  // Heap layout: node k has children 2k+1 / 2k+2, leaves start at pGROUP_N-1.
  node_t                  tree_r [NODES];

  // Left child always covers the lower indices, so ">=" gives the lower index the tie.
  function automatic node_t pick(node_t a, node_t b);
    return (a.vld && (!b.vld || a.val >= b.val)) ? a : b;
  endfunction

  always_comb begin
    for (int g = 0; g < pGROUP_N; g++) begin
      pre_c[g] = '0;
      for (int k = 0; k < pSUM_N - 1; k++)
        pre_c[g] = pre_c[g] + ACC_W'(isymb_m[(g*pSUM_N+k)*pSYMB_M_W +: pSYMB_M_W]);
    end
  end

  always_comb begin
    int               act_cnt;
    logic [ACC_W-1:0] sum;
    // NOTE: every variable gets a default before any conditional write, so no latch is inferred.
    sum     = '0;
    act_cnt = (int'(mode_r) > LOG_G) ? pGROUP_N : (1 << mode_r);
    for (int g = 0; g < pGROUP_N; g++) begin
      leaf_c[g] = '0;
      sum       = pre_r[g] + ACC_W'(last_r[g]);
      if (g < act_cnt) begin
        leaf_c[g].vld = 1'b1;
        leaf_c[g].idx = LOG_G'(g);
        leaf_c[g].sat = |sum[ACC_W-1:pBM_W];
        leaf_c[g].val = leaf_c[g].sat ? '1 : sum[pBM_W-1:0];
      end
    end
  end

  always_ff @(posedge iclk or negedge ireset_n) begin
    if (!ireset_n) begin
      vld_pipe <= '0;
      sop_pipe <= '0;
      eop_pipe <= '0;
    end else if (iclkena) begin
      vld_pipe <= {vld_pipe[L-2:0], ival};
      if (ival) begin
        sop_pipe[0] <= isop;
        eop_pipe[0] <= ieop;
      end
      for (int s = 1; s < L; s++) begin
        if (vld_pipe[s-1]) begin
          sop_pipe[s] <= sop_pipe[s-1];
          eop_pipe[s] <= eop_pipe[s-1];
        end
      end
    end
  end

  // NOTE: the data pipe is reset too (it is only a few registers) so obm/idx read 0 out of reset.
  always_ff @(posedge iclk or negedge ireset_n) begin
    if (!ireset_n) begin
      mode_r <= '0;
      for (int g = 0; g < pGROUP_N; g++) begin
        pre_r[g]  <= '0;
        last_r[g] <= '0;
      end
      for (int k = 0; k < NODES; k++)
        tree_r[k] <= '0;
    end else if (iclkena) begin
      if (ival) begin
        mode_r <= imode;
        for (int g = 0; g < pGROUP_N; g++) begin
          pre_r[g]  <= pre_c[g];
          last_r[g] <= isymb_m[((g+1)*pSUM_N-1)*pSYMB_M_W +: pSYMB_M_W];
        end
      end
      if (vld_pipe[0]) begin
        for (int g = 0; g < pGROUP_N; g++)
          tree_r[pGROUP_N-1+g] <= leaf_c[g];
      end
      // Depth d of the tree is loaded by compare stage LOG_G-d.
      for (int d = 0; d < LOG_G; d++) begin
        if (vld_pipe[LOG_G-d]) begin
          for (int k = (1 << d) - 1; k < (2 << d) - 1; k++)
            tree_r[k] <= pick(tree_r[2*k+1], tree_r[2*k+2]);
        end
      end
    end
  end

  assign oval        = vld_pipe[L-1];
  assign obm         = tree_r[0].val;
  assign osymb_m_idx = tree_r[0].idx;
  assign osat        = oval & tree_r[0].sat;
  assign osop        = oval & sop_pipe[L-1];
  assign oeop        = oval & eop_pipe[L-1];

endmodule

// File: tb/tb_tcm_dec_tmu_tree_n.sv
// Self-checking bench for tcm_dec_tmu_tree_n: five configurations share one stimulus
// stream, each checked against a per-beat max/saturation model and a latency stamp.
module tb_tcm_dec_tmu_tree_n;

  localparam int NDUT = 5;
  localparam int SW   = 16 * 5 * 8;
  localparam int BW   = 10;

  function automatic int cfg_g(int d);
    case (d)
      1:       return 2;
      2:       return 8;
      3:       return 16;
      default: return 4;
    endcase
  endfunction

  function automatic int cfg_s(int d);
    return (d == 4) ? 5 : 4;
  endfunction

  typedef struct {
    int bm;
    int idx;
    bit sat;
    bit sop;
    bit eop;
    int stamp;
  } exp_t;

  logic          iclk = 1'b0;
  logic          ireset_n;
  logic          iclkena;
  logic          ival;
  logic          isop;
  logic          ieop;
  logic [SW-1:0] stim;
  logic [4:0]    mode_d [NDUT];
  int            n_vec = 0;
  int            n_err = 0;
  bit            done  = 1'b0;

  always #5 iclk = ~iclk;

  task automatic check(input string tag, input longint obs, input longint exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Best candidate among the first 2^mode groups (clamped), strict max so lower index wins ties.
  function automatic void model(input int g_n, input int s_n, input logic [SW-1:0] v,
                                input int mode, output int bm, output int idx, output bit sat);
    int act;
    int sum;
    int val;
    act = (mode > $clog2(g_n)) ? g_n : (1 << mode);
    bm = 0; idx = 0; sat = 1'b0;
    for (int g = 0; g < act; g++) begin
      sum = 0;
      for (int k = 0; k < s_n; k++) sum += int'(v[(g*s_n+k)*8 +: 8]);
      val = (sum > 1023) ? 1023 : sum;
      if (g == 0 || val > bm) begin
        bm = val; idx = g; sat = (sum > 1023);
      end
    end
  endfunction

  for (genvar d = 0; d < NDUT; d++) begin : g_dut
    localparam int G  = cfg_g(d);
    localparam int S  = cfg_s(d);
    localparam int LG = $clog2(G);
    localparam int L  = 2 + LG;

    logic [LG:0]   mode_w;
    logic          ov, so, eo, sa;
    logic [BW-1:0] bm;
    logic [LG-1:0] ix;
    exp_t          q[$];
    exp_t          e;
    int            ena_cnt = 0;
    bit            en_prev = 1'b0;
    int            last_bm = 0;
    int            last_idx = 0;

    assign mode_w = mode_d[d][LG:0];

    tcm_dec_tmu_tree_n #(.pSYMB_M_W(8), .pSUM_N(S), .pGROUP_N(G)) u_dut (
      .iclk        (iclk),
      .ireset_n    (ireset_n),
      .iclkena     (iclkena),
      .ival        (ival),
      .isymb_m     (stim[G*S*8-1:0]),
      .imode       (mode_w),
      .isop        (isop),
      .ieop        (ieop),
      .oval        (ov),
      .obm         (bm),
      .osymb_m_idx (ix),
      .osop        (so),
      .oeop        (eo),
      .osat        (sa)
    );

    always @(posedge iclk) begin
      if (!ireset_n) begin
        q.delete();
        en_prev = 1'b0;
      end else begin
        en_prev = iclkena;
        if (iclkena) begin
          if (ival) begin
            model(G, S, stim, int'(mode_w), e.bm, e.idx, e.sat);
            e.sop = isop; e.eop = ieop; e.stamp = ena_cnt;
            q.push_back(e);
          end
          ena_cnt++;
        end
      end
    end

    always @(negedge iclk) begin
      if (!ireset_n) begin
        check($sformatf("d%0d_reset_outputs", d), longint'({ov, so, eo, sa, bm, ix}), 0);
        last_bm = 0; last_idx = 0;
      end else if (en_prev) begin
        if (ov) begin
          if (q.size() == 0) begin
            check($sformatf("d%0d_spurious_oval", d), 1, 0);
          end else begin
            e = q.pop_front();
            check($sformatf("d%0d_bm", d), longint'(bm), e.bm);
            check($sformatf("d%0d_idx", d), longint'(ix), e.idx);
            check($sformatf("d%0d_sat", d), longint'(sa), e.sat);
            check($sformatf("d%0d_sop_eop", d), longint'({so, eo}), longint'({e.sop, e.eop}));
            check($sformatf("d%0d_latency", d), ena_cnt - e.stamp, L);
            last_bm = e.bm; last_idx = e.idx;
          end
        end else begin
          check($sformatf("d%0d_qual_idle", d), longint'({so, eo, sa}), 0);
          check($sformatf("d%0d_hold_bm", d), longint'(bm), last_bm);
          check($sformatf("d%0d_hold_idx", d), longint'(ix), last_idx);
        end
      end
    end

    always @(posedge done) check($sformatf("d%0d_leftover_beats", d), q.size(), 0);
  end

  task automatic tick();
    @(posedge iclk);
    #1;
  endtask

  task automatic set_metric(input int s_n, input int g, input int k, input int val);
    stim[(g*s_n+k)*8 +: 8] = 8'(val);
  endtask

  // Spread a group sum over the four metrics of the default layout.
  task automatic set_sum(input int g, input int sum);
    int rem;
    int m;
    rem = sum;
    for (int k = 0; k < 4; k++) begin
      m = (rem > 255) ? 255 : rem;
      set_metric(4, g, k, m);
      rem -= m;
    end
  endtask

  task automatic set_modes(input int m);
    for (int d = 0; d < NDUT; d++) mode_d[d] = 5'(m);
  endtask

  task automatic launch(input bit sop, input bit eop);
    ival = 1'b1; isop = sop; ieop = eop;
    tick();
    ival = 1'b0; isop = 1'b0; ieop = 1'b0;
  endtask

  // Cycles from the capture edge until oval of DUT d (0 or 4); 99 when the bound expires.
  task automatic wait_out(input int d, output int lat);
    lat = 99;
    for (int n = 1; n <= 20; n++) begin
      @(negedge iclk);
      if ((d == 0 && g_dut[0].ov) || (d == 4 && g_dut[4].ov)) begin
        lat = n;
        break;
      end
    end
  endtask

  task automatic rand_stim();
    int kind;
    kind = $urandom_range(3, 0);
    for (int b = 0; b < SW / 8; b++) begin
      case (kind)
        0:       stim[b*8 +: 8] = 8'($urandom);
        1:       stim[b*8 +: 8] = $urandom_range(1, 0) ? 8'd255 : 8'd0;
        2:       stim[b*8 +: 8] = 8'($urandom_range(3, 0));
        default: stim[b*8 +: 8] = 8'($urandom_range(255, 200));
      endcase
    end
  endtask

  initial begin
    int lat;
    ireset_n = 1'b0; iclkena = 1'b1; ival = 1'b0; isop = 1'b0; ieop = 1'b0;
    stim = '0;
    set_modes(2);
    repeat (3) @(posedge iclk);
    #1 ireset_n = 1'b1;
    tick();

    // Single beat, tie between groups 1 and 3.
    stim = '0;
    set_sum(0, 10); set_sum(1, 40); set_sum(2, 25); set_sum(3, 40);
    launch(1'b1, 1'b1);
    wait_out(0, lat);
    check("dir_latency_default", lat, 4);
    check("dir_tie_bm", longint'(g_dut[0].bm), 40);
    check("dir_tie_idx", longint'(g_dut[0].ix), 1);
    tick();

    // Saturation on the five-metric configuration.
    stim = '0;
    for (int k = 0; k < 4; k++) set_metric(5, 2, k, 255);
    for (int k = 0; k < 5; k++) set_metric(5, 3, k, 255);
    launch(1'b0, 1'b0);
    wait_out(4, lat);
    check("dir_sat_latency", lat, 4);
    check("dir_sat_bm", longint'(g_dut[4].bm), 1023);
    check("dir_sat_idx", longint'(g_dut[4].ix), 3);
    check("dir_sat_flag", longint'(g_dut[4].sa), 1);
    tick();

    // Mode mask, then widened mode on the very next beat.
    stim = '0;
    set_sum(0, 5); set_sum(1, 6); set_sum(2, 900); set_sum(3, 1000);
    set_modes(1);
    ival = 1'b1;
    tick();
    set_modes(2);
    tick();
    ival = 1'b0;
    wait_out(0, lat);
    check("dir_mask_latency", lat, 3);
    check("dir_mask_bm", longint'(g_dut[0].bm), 6);
    check("dir_mask_idx", longint'(g_dut[0].ix), 1);
    @(negedge iclk);
    check("dir_mode2_val", longint'(g_dut[0].ov), 1);
    check("dir_mode2_bm", longint'(g_dut[0].bm), 1000);
    check("dir_mode2_idx", longint'(g_dut[0].ix), 3);
    repeat (8) tick();

    // Eight-beat frame with random clock-enable stalls.
    for (int b = 0; b < 8; b++) begin
      rand_stim();
      for (int d = 0; d < NDUT; d++) mode_d[d] = 5'($urandom_range(4, 0));
      launch(b == 0, b == 7);
      if ($urandom_range(1, 0) == 1) begin
        iclkena = 1'b0;
        repeat ($urandom_range(3, 1)) tick();
        iclkena = 1'b1;
      end
    end
    repeat (10) tick();

    // Reset with three beats in flight, then one beat after release.
    set_modes(2);
    ival = 1'b1;
    for (int b = 0; b < 3; b++) begin
      rand_stim();
      tick();
    end
    ival = 1'b0;
    #2 ireset_n = 1'b0;
    tick();
    tick();
    ireset_n = 1'b1;
    tick();
    stim = '0;
    set_sum(0, 300); set_sum(1, 700); set_sum(2, 700); set_sum(3, 100);
    launch(1'b1, 1'b0);
    wait_out(0, lat);
    check("dir_post_reset_latency", lat, 4);
    check("dir_post_reset_idx", longint'(g_dut[0].ix), 1);
    repeat (8) tick();

    // Random stream across all configurations, clamped modes and stalls included.
    for (int n = 0; n < 1000; n++) begin
      rand_stim();
      for (int d = 0; d < NDUT; d++)
        mode_d[d] = 5'($urandom_range((2 << $clog2(cfg_g(d))) - 1, 0));
      ival    = ($urandom_range(3, 0) != 0);
      iclkena = ($urandom_range(7, 0) != 0);
      isop    = $urandom_range(1, 0) == 1;
      ieop    = $urandom_range(1, 0) == 1;
      tick();
    end
    ival = 1'b0; iclkena = 1'b1; isop = 1'b0; ieop = 1'b0;
    repeat (12) tick();

    done = 1'b1;
    #1;
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
